axi_lat_injector: RTL and testbench

AXI_LAT_INJECTOR -- requirements
Module: axi_lat_injector

---
 rtl/axi_lat_injector.sv | 202 ++++++++++++++++++++
 tb/tb_axi_lat_injector.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lat_injector.sv
// axi_lat_injector: AXI latency injector. Each of the five channels (AW, W, B,
// AR, R) passes through its own small FIFO; a beat is released only once it
// has been stored for at least delay_i[channel] cycles.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   delay_i[5]              per-channel release delay (0=AW 1=W 2=B 3=AR 4=R)
//   aw/w/ar *_i / *_o       slave side in, master side out (valid/chan/ready)
//   b/r     *_i / *_o       master side in, slave side out (valid/chan/ready)
//   stall_cnt_o[5]          cycles each output sat valid without ready
//
// Optional feature: define AXI_LAT_INJECTOR_STATS_EN to build the stall
// counters; otherwise stall_cnt_o is tied to zero and no counter flops exist.

// One delayed channel: circular buffer with a saturating age per entry.
module axi_lat_injector_chan #(
    parameter type         T          = logic,
    parameter int unsigned Depth      = 4,
    parameter int unsigned DelayWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic                  valid_i,
    input  T                      chan_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output T                      chan_o,
    input  logic                  ready_i
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [DelayWidth-1:0] AgeMax = '1;

    T                      mem_q [Depth];
    logic [DelayWidth-1:0] age_q [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    // Ready depends only on occupancy, never on the downstream ready.
    assign ready_o = (cnt_q != CntW'(Depth));
    assign valid_o = (cnt_q != '0) && (age_q[rd_ptr_q] >= delay_i);
    assign chan_o  = mem_q[rd_ptr_q];
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Ages of empty slots also count; they are cleared on push, so harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (push && (wr_ptr_q == PtrW'(i))) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AgeMax) begin
                    age_q[i] <= age_q[i] + DelayWidth'(1);
                end
            end
        end
    end

    // Payload storage needs no reset: occupancy gates its visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= chan_i;
        end
    end
endmodule

module axi_lat_injector #(
    parameter type         aw_t       = logic,
    parameter type         w_t        = logic,
    parameter type         b_t        = logic,
    parameter type         ar_t       = logic,
    parameter type         r_t        = logic,
    parameter int unsigned Depth      = 4,
    parameter int unsigned DelayWidth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [4:0][DelayWidth-1:0] delay_i,
    // slave side
    input  logic                       aw_valid_i,
    input  aw_t                        aw_chan_i,
    output logic                       aw_ready_o,
    input  logic                       w_valid_i,
    input  w_t                         w_chan_i,
    output logic                       w_ready_o,
    input  logic                       ar_valid_i,
    input  ar_t                        ar_chan_i,
    output logic                       ar_ready_o,
    output logic                       b_valid_o,
    output b_t                         b_chan_o,
    input  logic                       b_ready_i,
    output logic                       r_valid_o,
    output r_t                         r_chan_o,
    input  logic                       r_ready_i,
    // master side
    output logic                       aw_valid_o,
    output aw_t                        aw_chan_o,
    input  logic                       aw_ready_i,
    output logic                       w_valid_o,
    output w_t                         w_chan_o,
    input  logic                       w_ready_i,
    output logic                       ar_valid_o,
    output ar_t                        ar_chan_o,
    input  logic                       ar_ready_i,
    input  logic                       b_valid_i,
    input  b_t                         b_chan_i,
    output logic                       b_ready_o,
    input  logic                       r_valid_i,
    input  r_t                         r_chan_i,
    output logic                       r_ready_o,
    output logic [4:0][31:0]           stall_cnt_o
);
    axi_lat_injector_chan #(.T(aw_t), .Depth(Depth), .DelayWidth(DelayWidth)) u_aw (
        .clk_i(clk_i), .rst_ni(rst_ni), .delay_i(delay_i[0]),
        .valid_i(aw_valid_i), .chan_i(aw_chan_i), .ready_o(aw_ready_o),
        .valid_o(aw_valid_o), .chan_o(aw_chan_o), .ready_i(aw_ready_i)
    );
    axi_lat_injector_chan #(.T(w_t), .Depth(Depth), .DelayWidth(DelayWidth)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni), .delay_i(delay_i[1]),
        .valid_i(w_valid_i), .chan_i(w_chan_i), .ready_o(w_ready_o),
        .valid_o(w_valid_o), .chan_o(w_chan_o), .ready_i(w_ready_i)
    );
    axi_lat_injector_chan #(.T(b_t), .Depth(Depth), .DelayWidth(DelayWidth)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .delay_i(delay_i[2]),
        .valid_i(b_valid_i), .chan_i(b_chan_i), .ready_o(b_ready_o),
        .valid_o(b_valid_o), .chan_o(b_chan_o), .ready_i(b_ready_i)
    );
    axi_lat_injector_chan #(.T(ar_t), .Depth(Depth), .DelayWidth(DelayWidth)) u_ar (
        .clk_i(clk_i), .rst_ni(rst_ni), .delay_i(delay_i[3]),
        .valid_i(ar_valid_i), .chan_i(ar_chan_i), .ready_o(ar_ready_o),
        .valid_o(ar_valid_o), .chan_o(ar_chan_o), .ready_i(ar_ready_i)
    );
    axi_lat_injector_chan #(.T(r_t), .Depth(Depth), .DelayWidth(DelayWidth)) u_r (
        .clk_i(clk_i), .rst_ni(rst_ni), .delay_i(delay_i[4]),
        .valid_i(r_valid_i), .chan_i(r_chan_i), .ready_o(r_ready_o),
        .valid_o(r_valid_o), .chan_o(r_chan_o), .ready_i(r_ready_i)
    );

`ifdef AXI_LAT_INJECTOR_STATS_EN
    logic [4:0] out_valid;
    logic [4:0] out_ready;
    logic [4:0][31:0] stall_cnt_q;

    assign out_valid = {r_valid_o, ar_valid_o, b_valid_o, w_valid_o, aw_valid_o};
    assign out_ready = {r_ready_i, ar_ready_i, b_ready_i, w_ready_i, aw_ready_i};

    // Free-running stall counters; wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned c = 0; c < 5; c++) begin
                if (out_valid[c] && !out_ready[c]) begin
                    stall_cnt_q[c] <= stall_cnt_q[c] + 32'd1;
                end
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_axi_lat_injector.sv
// Bench for axi_lat_injector: per-channel latency vectors plus directed
// sequences for burst order, full FIFO, live delay change, reset and
// age saturation (second instance with DelayWidth = 4).
module tb_axi_lat_injector;
    typedef logic [15:0] data_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [4:0][7:0]      delay;
    logic [4:0]           in_valid;
    logic [4:0][15:0]     in_data;
    logic [4:0]           out_ready;
    wire  [4:0]           in_ready;
    wire  [4:0]           out_valid;
    wire  [4:0][15:0]     out_data;
    wire  [4:0][31:0]     stall_cnt;

    // small instance: DelayWidth 4, only the AW channel is exercised
    logic [4:0][3:0]      s_delay;
    logic                 s_valid;
    logic [15:0]          s_data;
    logic                 s_ready;
    wire  [4:0]           s_in_ready;
    wire  [4:0]           s_out_valid;
    wire  [4:0][15:0]     s_out_data;
    wire  [4:0][31:0]     s_stall;

    axi_lat_injector #(
        .aw_t(data_t), .w_t(data_t), .b_t(data_t), .ar_t(data_t), .r_t(data_t),
        .Depth(4), .DelayWidth(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .delay_i(delay),
        .aw_valid_i(in_valid[0]), .aw_chan_i(in_data[0]), .aw_ready_o(in_ready[0]),
        .w_valid_i(in_valid[1]),  .w_chan_i(in_data[1]),  .w_ready_o(in_ready[1]),
        .ar_valid_i(in_valid[3]), .ar_chan_i(in_data[3]), .ar_ready_o(in_ready[3]),
        .b_valid_o(out_valid[2]), .b_chan_o(out_data[2]), .b_ready_i(out_ready[2]),
        .r_valid_o(out_valid[4]), .r_chan_o(out_data[4]), .r_ready_i(out_ready[4]),
        .aw_valid_o(out_valid[0]), .aw_chan_o(out_data[0]), .aw_ready_i(out_ready[0]),
        .w_valid_o(out_valid[1]),  .w_chan_o(out_data[1]),  .w_ready_i(out_ready[1]),
        .ar_valid_o(out_valid[3]), .ar_chan_o(out_data[3]), .ar_ready_i(out_ready[3]),
        .b_valid_i(in_valid[2]), .b_chan_i(in_data[2]), .b_ready_o(in_ready[2]),
        .r_valid_i(in_valid[4]), .r_chan_i(in_data[4]), .r_ready_o(in_ready[4]),
        .stall_cnt_o(stall_cnt)
    );

    axi_lat_injector #(
        .aw_t(data_t), .w_t(data_t), .b_t(data_t), .ar_t(data_t), .r_t(data_t),
        .Depth(2), .DelayWidth(4)
    ) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .delay_i(s_delay),
        .aw_valid_i(s_valid), .aw_chan_i(s_data), .aw_ready_o(s_in_ready[0]),
        .w_valid_i(1'b0),  .w_chan_i(16'h0),  .w_ready_o(s_in_ready[1]),
        .ar_valid_i(1'b0), .ar_chan_i(16'h0), .ar_ready_o(s_in_ready[3]),
        .b_valid_o(s_out_valid[2]), .b_chan_o(s_out_data[2]), .b_ready_i(1'b1),
        .r_valid_o(s_out_valid[4]), .r_chan_o(s_out_data[4]), .r_ready_i(1'b1),
        .aw_valid_o(s_out_valid[0]), .aw_chan_o(s_out_data[0]), .aw_ready_i(s_ready),
        .w_valid_o(s_out_valid[1]),  .w_chan_o(s_out_data[1]),  .w_ready_i(1'b1),
        .ar_valid_o(s_out_valid[3]), .ar_chan_o(s_out_data[3]), .ar_ready_i(1'b1),
        .b_valid_i(1'b0), .b_chan_i(16'h0), .b_ready_o(s_in_ready[2]),
        .r_valid_i(1'b0), .r_chan_i(16'h0), .r_ready_o(s_in_ready[4]),
        .stall_cnt_o(s_stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted just after a rising edge, released on the falling edge.
    task automatic do_reset();
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        delay     = '0;
        s_delay   = '0;
        s_valid   = 1'b0;
        s_data    = 16'h0;
        s_ready   = 1'b1;
        step();
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        int          ch;
        int          dly;
        logic [15:0] data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int idx;
        int popped;
        int order_err;
        int seen;
        int emits;
        logic acc;
        int got_c [8];
        logic [15:0] got_d [8];
        longint exp_stall;

        // single-beat latency = delay + 1 cycles after the push cycle
        vecs[0] = '{ch: 0, dly: 0,  data: 16'hA5A5, exp_lat: 1};
        vecs[1] = '{ch: 1, dly: 3,  data: 16'h1234, exp_lat: 4};
        vecs[2] = '{ch: 2, dly: 1,  data: 16'hBEEF, exp_lat: 2};
        vecs[3] = '{ch: 3, dly: 7,  data: 16'h0F0F, exp_lat: 8};
        vecs[4] = '{ch: 4, dly: 2,  data: 16'hC0DE, exp_lat: 3};
        vecs[5] = '{ch: 0, dly: 15, data: 16'h5A5A, exp_lat: 16};

        rst_n = 1'b1;
        do_reset();

        // reset state
        for (int c = 0; c < 5; c++) begin
            check($sformatf("rst_valid_o[%0d]", c), out_valid[c], 0);
            check($sformatf("rst_ready_o[%0d]", c), in_ready[c], 1);
            check($sformatf("rst_stall[%0d]", c), stall_cnt[c], 0);
        end
        check("sat_idle_valid", s_out_valid, 0);
        check("sat_idle_ready", s_in_ready, 5'h1f);
        check("sat_idle_stall", s_stall, 0);

        // table-driven single beat latency
        for (int v = 0; v < 6; v++) begin
            delay[vecs[v].ch]    = 8'(vecs[v].dly);
            in_valid[vecs[v].ch] = 1'b1;
            in_data[vecs[v].ch]  = vecs[v].data;
            step();
            in_valid[vecs[v].ch] = 1'b0;
            #1;
            lat = 1;
            while (!out_valid[vecs[v].ch] && lat < 64) begin
                step();
                #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_payload", v), out_data[vecs[v].ch], vecs[v].data);
            step();
            #1;
            check($sformatf("vec%0d_one_cycle", v), out_valid[vecs[v].ch], 0);
            delay[vecs[v].ch] = 8'd0;
        end

        // four back-to-back W beats, delay 10 -> cycles 11..14
        do_reset();
        delay[1] = 8'd10;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid[1] = (c < 4);
            in_data[1]  = 16'h0100 + 16'(c);
            #1;
            if (out_valid[1]) begin
                if (n < 8) begin
                    got_c[n] = c;
                    got_d[n] = out_data[1];
                end
                n++;
            end
            step();
        end
        in_valid[1] = 1'b0;
        check("w_burst_count", n, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w_burst_cycle%0d", k), got_c[k], 11 + k);
            check($sformatf("w_burst_data%0d", k), got_d[k], 16'h0100 + k);
        end

        // full FIFO: 6 AR beats offered with ar_ready_i low
        do_reset();
        out_ready[3] = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid[3] = 1'b1;
            in_data[3]  = 16'h0300 + 16'(idx);
            #1;
            acc = in_ready[3];
            step();
            if (acc) idx++;
        end
        #1;
        check("ar_accepted_when_full", idx, 4);
        check("ar_ready_o_full", in_ready[3], 0);
        check("ar_valid_o_held", out_valid[3], 1);
        out_ready[3] = 1'b1;
        popped = 0;
        order_err = 0;
        for (int c = 0; c < 30 && popped < 6; c++) begin
            in_valid[3] = (idx < 6);
            in_data[3]  = 16'h0300 + 16'(idx);
            #1;
            acc = in_ready[3] && in_valid[3];
            if (out_valid[3]) begin
                if (out_data[3] != 16'h0300 + 16'(popped)) order_err++;
                popped++;
            end
            step();
            if (acc) idx++;
        end
        in_valid[3] = 1'b0;
        check("ar_drain_count", popped, 6);
        check("ar_drain_order_errors", order_err, 0);

        // delay 200 lowered to 0 from cycle 51 -> release in 51,52,53
        do_reset();
        delay[4] = 8'd200;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid[4] = (c < 3);
            in_data[4]  = 16'h0400 + 16'(c);
            if (c == 51) delay[4] = 8'd0;
            #1;
            if (out_valid[4]) begin
                if (n < 8) begin
                    got_c[n] = c;
                    got_d[n] = out_data[4];
                end
                n++;
            end
            step();
        end
        in_valid[4] = 1'b0;
        check("r_release_count", n, 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("r_release_cycle%0d", k), got_c[k], 51 + k);
            check($sformatf("r_release_data%0d", k), got_d[k], 16'h0400 + k);
        end

        // B beat stalled 7 cycles, then reset discards it
        do_reset();
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b1;
        in_data[2]   = 16'hB0B0;
        step();
        in_valid[2] = 1'b0;
        repeat (7) step();
        #1;
`ifdef AXI_LAT_INJECTOR_STATS_EN
        exp_stall = 7;
`else
        exp_stall = 0;
`endif
        check("b_valid_before_reset", out_valid[2], 1);
        check("b_payload_stable", out_data[2], 16'hB0B0);
        check("b_stall_cnt", stall_cnt[2], exp_stall);
        rst_n = 1'b0;
        #1;
        check("b_valid_in_reset", out_valid[2], 0);
        check("b_stall_in_reset", stall_cnt[2], 0);
        #2;
        rst_n = 1'b1;
        out_ready[2] = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            if (out_valid[2]) seen++;
        end
        check("b_valid_after_release", seen, 0);
        check("b_ready_o_after_release", in_ready[2], 1);

        // DelayWidth 4, delay 15: age saturates, beat stays valid
        do_reset();
        s_delay[0] = 4'd15;
        s_ready    = 1'b0;
        s_valid    = 1'b1;
        s_data     = 16'h3131;
        step();
        s_valid = 1'b0;
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (s_out_valid[0]) seen++;
            step();
        end
        check("sat_valid_cycles", seen, 25);
        s_ready = 1'b1;
        emits = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (s_out_valid[0]) begin
                emits++;
                check("sat_payload", s_out_data[0], 16'h3131);
            end
            step();
        end
        check("sat_emissions", emits, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
